// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-bypass network for the MIPS pipeline.
// Tracks the destination register of every in-flight instruction in the
// DEPTH stages after decode. For each decode read port it picks the youngest
// ready forwarding source, and it raises a load-use stall when the youngest
// matching writer has not produced its data yet.
module fwd_scoreboard #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                hold,
    input  logic                iss_valid,
    input  logic                iss_wen,
    input  logic [AW-1:0]       iss_waddr,
    input  logic [SW-1:0]       iss_rdy_stg,
    input  logic [DEPTH*DW-1:0] stg_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD*DW-1:0]   rd_gpr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD*SW-1:0]   rd_src,
    output logic                stall,
    output logic [31:0]         stall_cnt
);

    // Entry k describes the instruction currently in post-decode stage k.
    logic [DEPTH-1:0]         v_q, v_d;
    logic [DEPTH-1:0][AW-1:0] waddr_q, waddr_d;
    logic [DEPTH-1:0][SW-1:0] rdy_q, rdy_d;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    logic [NRD-1:0]           found;
    logic [NRD-1:0]           not_rdy;

    // Per-port source select: the lowest matching stage (youngest writer) wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the loops can leave it unassigned and infer a latch.
        rd_data = rd_gpr;
        rd_src  = '0;
        found   = '0;
        not_rdy = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found[p] && v_q[k] && (waddr_q[k] != '0) &&
                    (waddr_q[k] == rd_addr[p*AW +: AW])) begin
                    found[p] = 1'b1;
                    if (int'(rdy_q[k]) <= k) begin
                        rd_data[p*DW +: DW] = stg_data[k*DW +: DW];
                        rd_src[p*SW +: SW]  = SW'(k + 1);
                    end else begin
                        // Youngest writer not ready yet: an older copy would be stale.
                        not_rdy[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Stall only matters when decode actually wants to issue.
    assign stall = iss_valid && (|not_rdy);

    // Next entry state: flush clears, hold freezes, otherwise shift one stage.
    always_comb begin
        v_d     = v_q;
        waddr_d = waddr_q;
        rdy_d   = rdy_q;
        if (flush) begin
            v_d = '0;
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]     = v_q[k-1];
                waddr_d[k] = waddr_q[k-1];
                rdy_d[k]   = rdy_q[k-1];
            end
            // A stalled issue enters stage 0 as a bubble.
            v_d[0]     = iss_valid && iss_wen && !stall;
            waddr_d[0] = iss_waddr;
            rdy_d[0]   = iss_rdy_stg;
        end
    end

    // Saturating count of cycles in which a stall actually held decode back.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Valid bits and counter: synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Entry payload register.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; it is only observed through its valid
        // bit, which is, so a reset here would buy nothing.
        waddr_q <= waddr_d;
        rdy_q   <= rdy_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-bypass network with an in-flight writer scoreboard for the MIPS pipeline.
- Tracks the destination register of every instruction in the DEPTH stages after decode (stage 0 = EX, 1 = MEM1, 2 = MEM2 by default).
- For each of NRD decode read ports, selects the youngest ready forwarding source, or the GPR value when there is no match.
- Raises a load-use stall when the youngest matching writer has not yet produced its data.
- Counts stall cycles for performance monitoring.

Parameters:
DW, 32, data width
AW, 5, register address width
NRD, 2, number of decode read ports
DEPTH, 3, tracked post-decode stages (≥1)
SW, $clog2(DEPTH+1), width of the source/ready-stage encodings (derived)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  invalidate all tracked entries
hold  in  1  pipeline freeze; entries keep their values
iss_valid  in  1  decode instruction requests issue into stage 0
iss_wen  in  1  issuing instruction writes a GPR
iss_waddr  in  AW  its destination register
iss_rdy_stg  in  SW  first stage index whose stg_data carries its result
stg_data  in  DEPTH*DW  result bus of stage k in slice k
rd_addr  in  NRD*AW  decode source register per port
rd_gpr  in  NRD*DW  register-file read value per port
rd_data  out  NRD*DW  forwarded operand per port
rd_src  out  NRD*SW  0 = GPR, k+1 = stage k
stall  out  1  decode must not issue
stall_cnt  out  32  saturating stall-cycle counter

Behaviour:
- The clock is clk. Reset is synchronous and active-low on rst_n: on a rising edge with rst_n=0, all entries become invalid and stall_cnt=0.
  - After reset: stall=0, rd_src=0, rd_data=rd_gpr. These hold until the next issue.
- Entry k = {v, waddr, rdy} describes the instruction currently in stage k.
- Entry match for port p: v && waddr==rd_addr[p] && waddr!=0. Register 0 never matches.
- Per port (combinational): find the lowest k with a match (youngest writer wins).
  - If rdy<=k: rd_data = stg_data[k], rd_src = k+1.
  - If rdy>k: port not ready; rd_data = rd_gpr, rd_src = 0.
  - No match: rd_data = rd_gpr, rd_src = 0.
- stall = iss_valid && any port not ready. stall is combinational and does not depend on hold.
- Sequential update, in priority order:
  - rst_n=0: as above.
  - else flush: all v<=0. stall_cnt is unchanged.
  - else hold: entries keep their values. stall_cnt is unchanged.
  - else: entry k <= entry k-1 for k≥1. Entry 0 <= {iss_valid && iss_wen && !stall, iss_waddr, iss_rdy_stg}.
    - A stalled issue inserts a bubble (v=0).
    - Entry DEPTH-1 retires.
- stall_cnt increments when stall && !hold && !flush, and saturates at 0xFFFFFFFF.
- iss_rdy_stg ≥ DEPTH means the result is never forwardable. Any read of that register stalls until the entry retires.
- Simultaneous flush and hold: flush wins.
- Reset mid-stall: clears immediately; stall drops in the following cycle.
- rd_addr values on different ports are independent. Two ports may resolve to the same entry.

Test Plan:
1. Reset: rst_n=0 for one edge with iss_valid=1, iss_wen=1, iss_waddr=5 → all entries invalid; rd_addr0=5 gives rd_src0=0, rd_data0=rd_gpr0; stall_cnt=0.
2. EX forward: issue waddr=5, rdy=0; next cycle rd_addr0=5, stg_data[0]=0x00001234 → rd_data0=0x00001234, rd_src0=1, stall=0. Two cycles later, src=3 with stg_data[2]. After DEPTH cycles → src=0.
3. Load-use: issue waddr=8, rdy=1; next cycle iss_valid=1, rd_addr1=8 → stall=1, bubble inserted. Following cycle → stall=0, rd_src1=2, rd_data1=stg_data[1]; stall_cnt=1.
4. Youngest priority and $0:
   - Issue waddr=3 in consecutive cycles, rdy=0 → rd_addr0=3 gives src=1, not 2.
   - Issue waddr=0 → rd_addr=0 gives src=0, stall=0.
5. Hold then flush: issue waddr=7, rdy=1; hold=1 for 2 cycles → stall stays 1, entry stays at stage 0, stall_cnt unchanged. Then flush=1 with hold=1 → next cycle src=0, stall=0.
6. Never-forwardable: DEPTH=3, issue waddr=9, rdy=3 → reading 9 stalls for 3 consecutive cycles, then src=0; stall_cnt=3.
